// File: rtl/clock_time_set.sv
// clock_time_set -- timekeeping and adjust core of the Reloj clock.
//
// Keeps the 24 h time (hora:minuto:segundo) and the alarm time
// (alm_hora:alm_min), applies push-button adjustments according to the
// synchronized mode code, and drives the alarm output.
//
// Mode code (mode_sel): 00 run, 01 set hour, 10 set minute, 11 set alarm.
//
// Parameters:
//   TICK_DIV    clk cycles per 1 s tick (must be >= 2)
//   ALARM_SECS  seconds the alarm stays asserted if not cancelled
//   REPEAT_DIV  clk cycles per auto-repeat increment (auto-repeat build only)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous reset, active low
//   mode_sel   mode code, asynchronous to clk
//   btn_inc    increment button, raw level
//   btn_sel    alarm field-select button, raw level
//   alarm_en   alarm enable switch, raw level
//   hora       current hour 0-23
//   minuto     current minute 0-59
//   segundo    current second 0-59
//   alm_hora   alarm hour 0-23
//   alm_min    alarm minute 0-59
//   alm_field  mode 11 field select: 0 hour, 1 minute
//   tick       one-cycle pulse per counted second
//   alarma     alarm/buzzer output
//
// Build option: define CLOCK_TIME_SET_AUTOREPEAT_EN to add auto-repeat of
// btn_inc in modes 01, 10 and 11. Without it a held button yields exactly
// one increment.

module clock_time_set #(
  parameter int TICK_DIV   = 50000000,
  parameter int ALARM_SECS = 60,
  parameter int REPEAT_DIV = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode_sel,
  input  logic       btn_inc,
  input  logic       btn_sel,
  input  logic       alarm_en,
  output logic [4:0] hora,
  output logic [5:0] minuto,
  output logic [5:0] segundo,
  output logic [4:0] alm_hora,
  output logic [5:0] alm_min,
  output logic       alm_field,
  output logic       tick,
  output logic       alarma
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam int AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
  localparam logic [AW-1:0] ALM_MAX = AW'(ALARM_SECS - 1);

  localparam logic [1:0] M_RUN = 2'b00;
  localparam logic [1:0] M_HR  = 2'b01;
  localparam logic [1:0] M_MIN = 2'b10;
  localparam logic [1:0] M_ALM = 2'b11;

  // tick is decoded from the prescaler, so a divide of 1 would leave it
  // stuck high; REPEAT_DIV must give a non-empty repeat period.
  if (TICK_DIV < 2 || REPEAT_DIV < 1) begin : g_param_check
    $error("clock_time_set: TICK_DIV must be >= 2 and REPEAT_DIV >= 1");
  end

  function automatic logic [4:0] inc_hour(input logic [4:0] h);
    return (h == 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [5:0] inc_min60(input logic [5:0] m);
    return (m == 6'd59) ? 6'd0 : m + 6'd1;
  endfunction

  // Synchronizer / edge-detect flops: _p0, _p1 form the 2-flop synchronizer,
  // _p2 holds the previous synchronized value.
  logic [1:0] mode_p0, mode_p1, mode_p2;
  logic       inc_p0, inc_p1, inc_p2;
  logic       sel_p0, sel_p1, sel_p2;
  logic       en_p0, en_p1;

  logic [PW-1:0] pre_cnt;
  logic [AW-1:0] alm_cnt;

  logic [1:0] mode;
  logic       run_mode, adj_mode;
  logic       inc_edge, sel_edge, inc_ev;
  logic       enter_alm;
  logic       field_eff;
  logic       alarm_set, alarm_clr;

  logic [PW-1:0] pre_n;
  logic [5:0]    sec_n, min_n;
  logic [4:0]    hr_n;
  logic [4:0]    alm_hr_n;
  logic [5:0]    alm_min_n;
  logic          field_n;

  assign mode      = mode_p1;
  assign run_mode  = (mode == M_RUN) || (mode == M_ALM);
  assign adj_mode  = ~run_mode;
  assign inc_edge  = inc_p1 & ~inc_p2;
  assign sel_edge  = sel_p1 & ~sel_p2;
  assign enter_alm = (mode == M_ALM) && (mode_p2 != M_ALM);
  assign tick      = run_mode && (pre_cnt == PRE_MAX);

`ifdef CLOCK_TIME_SET_AUTOREPEAT_EN
  localparam int RW = (REPEAT_DIV > 1) ? $clog2(REPEAT_DIV) : 1;
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_DIV - 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_run, rep_fire;

  // The counter only runs while the button is held in an adjust-capable
  // mode that has not just changed.
  assign rep_run  = inc_p1 && (mode != M_RUN) && (mode == mode_p2);
  assign rep_fire = rep_run && (rep_cnt == REP_MAX);
  assign inc_ev   = inc_edge | rep_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else if (!rep_run || rep_fire) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end
`else
  assign inc_ev = inc_edge;
`endif

  // Field used by an increment in this cycle: entering mode 11 selects the
  // hour field immediately, so a coincident inc edge adjusts the hour.
  assign field_eff = enter_alm ? 1'b0 : alm_field;

  always_comb begin
    pre_n     = pre_cnt;
    sec_n     = segundo;
    min_n     = minuto;
    hr_n      = hora;
    alm_hr_n  = alm_hora;
    alm_min_n = alm_min;
    field_n   = alm_field;

    if (run_mode) begin
      pre_n = (pre_cnt == PRE_MAX) ? '0 : pre_cnt + 1'b1;
      if (tick) begin
        if (segundo == 6'd59) begin
          sec_n = 6'd0;
          if (minuto == 6'd59) begin
            min_n = 6'd0;
            hr_n  = inc_hour(hora);
          end else begin
            min_n = minuto + 6'd1;
          end
        end else begin
          sec_n = segundo + 6'd1;
        end
      end
    end else begin
      pre_n = '0;
      sec_n = 6'd0;
      if (inc_ev) begin
        if (mode == M_HR) hr_n  = inc_hour(hora);
        else              min_n = inc_min60(minuto);
      end
    end

    if (mode == M_ALM) begin
      if (enter_alm)     field_n = 1'b0;
      else if (sel_edge) field_n = ~alm_field;
      if (inc_ev) begin
        if (!field_eff) alm_hr_n  = inc_hour(alm_hora);
        else            alm_min_n = inc_min60(alm_min);
      end
    end
  end

  // Only a run tick landing exactly on hh:mm:00 arms the alarm; manual
  // adjustment never produces a tick, so it cannot trigger it.
  assign alarm_set = tick && en_p1 && (hr_n == alm_hora) &&
                     (min_n == alm_min) && (sec_n == 6'd0);
  assign alarm_clr = ~en_p1 || inc_ev || sel_edge || adj_mode ||
                     (alarma && tick && (alm_cnt == ALM_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_p0   <= 2'b00;
      mode_p1   <= 2'b00;
      mode_p2   <= 2'b00;
      inc_p0    <= 1'b0;
      inc_p1    <= 1'b0;
      inc_p2    <= 1'b0;
      sel_p0    <= 1'b0;
      sel_p1    <= 1'b0;
      sel_p2    <= 1'b0;
      en_p0     <= 1'b0;
      en_p1     <= 1'b0;
      pre_cnt   <= '0;
      alm_cnt   <= '0;
      segundo   <= 6'd0;
      minuto    <= 6'd0;
      hora      <= 5'd0;
      alm_hora  <= 5'd6;
      alm_min   <= 6'd0;
      alm_field <= 1'b0;
      alarma    <= 1'b0;
    end else begin
      // Stage p0 -> p1 -> p2: synchronize, then keep previous for edges
      mode_p0 <= mode_sel;
      mode_p1 <= mode_p0;
      mode_p2 <= mode_p1;
      inc_p0  <= btn_inc;
      inc_p1  <= inc_p0;
      inc_p2  <= inc_p1;
      sel_p0  <= btn_sel;
      sel_p1  <= sel_p0;
      sel_p2  <= sel_p1;
      en_p0   <= alarm_en;
      en_p1   <= en_p0;

      // Time, alarm settings and alarm output from synchronized inputs
      pre_cnt   <= pre_n;
      segundo   <= sec_n;
      minuto    <= min_n;
      hora      <= hr_n;
      alm_hora  <= alm_hr_n;
      alm_min   <= alm_min_n;
      alm_field <= field_n;

      if (alarm_clr)      alarma <= 1'b0;
      else if (alarm_set) alarma <= 1'b1;

      if (alarm_set)                                alm_cnt <= '0;
      else if (alarma && tick && alm_cnt != ALM_MAX) alm_cnt <= alm_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_clock_time_set.sv
module tb_clock_time_set;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode_sel = 2'b00;
  logic       btn_inc = 1'b0;
  logic       btn_sel = 1'b0;
  logic       alarm_en = 1'b0;
  logic [4:0] hora;
  logic [5:0] minuto;
  logic [5:0] segundo;
  logic [4:0] alm_hora;
  logic [5:0] alm_min;
  logic       alm_field;
  logic       tick;
  logic       alarma;

  clock_time_set #(.TICK_DIV(TD), .ALARM_SECS(60), .REPEAT_DIV(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_sel  (mode_sel),
    .btn_inc   (btn_inc),
    .btn_sel   (btn_sel),
    .alarm_en  (alarm_en),
    .hora      (hora),
    .minuto    (minuto),
    .segundo   (segundo),
    .alm_hora  (alm_hora),
    .alm_min   (alm_min),
    .alm_field (alm_field),
    .tick      (tick),
    .alarma    (alarma)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int tick_cnt = 0;
  logic [31:0] exp_q[$];

  always @(posedge clk) if (tick === 1'b1) tick_cnt <= tick_cnt + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] act);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check(tag, act, e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_inc();
    btn_inc = 1'b1; cyc(5);
    btn_inc = 1'b0; cyc(5);
  endtask

  task automatic press_sel();
    btn_sel = 1'b1; cyc(5);
    btn_sel = 1'b0; cyc(5);
  endtask

  task automatic set_mode(input logic [1:0] m);
    mode_sel = m;
    cyc(4);
  endtask

  task automatic wait_ticks(input int n);
    int tgt;
    int b;
    tgt = tick_cnt + n;
    b = 0;
    while (tick_cnt < tgt && b < n * TD * 3 + 20) begin
      @(negedge clk);
      b++;
    end
    if (tick_cnt < tgt) check("tick_timeout", tick_cnt, tgt);
  endtask

  initial begin
    int eh, em, eah, eam, t0, k;

    // Reset values
    cyc(3);
    push(0); pop_chk("rst_hora", hora);
    push(0); pop_chk("rst_min", minuto);
    push(0); pop_chk("rst_sec", segundo);
    push(6); pop_chk("rst_alm_hora", alm_hora);
    push(0); pop_chk("rst_alm_min", alm_min);
    push(0); pop_chk("rst_field", alm_field);
    push(0); pop_chk("rst_alarma", alarma);
    push(0); pop_chk("rst_tick", tick);

    // Run: first second after 4 clocks, one minute after 240
    rst_n = 1'b1;
    cyc(3);
    push(0); pop_chk("run_sec_pre", segundo);
    cyc(1);
    push(1); pop_chk("run_sec_first", segundo);
    cyc(236);
    push(0);  pop_chk("run_hora", hora);
    push(1);  pop_chk("run_min", minuto);
    push(0);  pop_chk("run_sec", segundo);
    push(60); pop_chk("run_ticks", tick_cnt);

    // Mode 01: 25 presses, seconds held, no ticks
    set_mode(2'b01);
    t0 = tick_cnt;
    eh = 0;
    for (int i = 0; i < 25; i++) begin
      press_inc();
      eh = (eh + 1) % 24;
      push(eh); pop_chk("m01_hora", hora);
      push(0);  pop_chk("m01_sec", segundo);
    end
    push(t0); pop_chk("m01_no_ticks", tick_cnt);
    push(1);  pop_chk("m01_min_kept", minuto);

    // Held button yields exactly one increment
    btn_inc = 1'b1; cyc(20);
    btn_inc = 1'b0; cyc(5);
    eh = (eh + 1) % 24;
    push(eh); pop_chk("m01_held", hora);

    // Rollover 23:59:59 -> 00:00:00
    while (eh != 23) begin
      press_inc();
      eh = (eh + 1) % 24;
    end
    push(23); pop_chk("roll_set_hora", hora);
    set_mode(2'b10);
    em = 1;
    while (em != 59) begin
      press_inc();
      em = (em + 1) % 60;
    end
    push(59); pop_chk("roll_set_min", minuto);
    push(23); pop_chk("roll_m10_hora", hora);
    set_mode(2'b00);
    wait_ticks(59);
    push(23); pop_chk("roll_pre_hora", hora);
    push(59); pop_chk("roll_pre_min", minuto);
    push(59); pop_chk("roll_pre_sec", segundo);
    wait_ticks(1);
    push(0); pop_chk("roll_hora", hora);
    push(0); pop_chk("roll_min", minuto);
    push(0); pop_chk("roll_sec", segundo);

    // Mode 10 wrap without carry into hora
    set_mode(2'b10);
    em = 0;
    while (em != 58) begin
      press_inc();
      em = em + 1;
    end
    push(58); pop_chk("m10_min58", minuto);
    for (int i = 0; i < 3; i++) begin
      press_inc();
      em = (em + 1) % 60;
      push(em); pop_chk("m10_wrap_min", minuto);
      push(0);  pop_chk("m10_wrap_hora", hora);
    end

    // Mode 11: field forced to hour on entry, sel toggles, inc adjusts
    set_mode(2'b11);
    push(0); pop_chk("m11_entry_field", alm_field);
    press_sel();
    push(1); pop_chk("m11_sel", alm_field);
    set_mode(2'b00);
    push(1); pop_chk("m00_field_held", alm_field);
    set_mode(2'b11);
    push(0); pop_chk("m11_reentry_field", alm_field);
    press_sel();
    push(1); pop_chk("m11_sel2", alm_field);
    t0 = tick_cnt;
    eam = 0;
    for (int i = 0; i < 2; i++) begin
      press_inc();
      eam = (eam + 1) % 60;
      push(eam); pop_chk("m11_alm_min", alm_min);
    end
    push(6); pop_chk("m11_alm_hora_kept", alm_hora);
    push(1); pop_chk("m11_time_runs", tick_cnt > t0);
    press_sel();
    push(0); pop_chk("m11_sel_back", alm_field);
    eah = 6;
    for (int i = 0; i < 18; i++) begin
      press_inc();
      eah = (eah + 1) % 24;
    end
    push(eah); pop_chk("m11_alm_hora_wrap", alm_hora);
    push(2);   pop_chk("m11_alm_min_kept", alm_min);

    // Alarm: set time to 00:01:00, run to 00:01:59, then the match tick
    set_mode(2'b01);
    k = (24 - int'(hora)) % 24;
    repeat (k) press_inc();
    set_mode(2'b10);
    k = (61 - int'(minuto)) % 60;
    repeat (k) press_inc();
    push(0); pop_chk("alm_setup_hora", hora);
    push(1); pop_chk("alm_setup_min", minuto);
    alarm_en = 1'b1;
    set_mode(2'b00);
    wait_ticks(59);
    push(59); pop_chk("alm_pre_sec", segundo);
    push(0);  pop_chk("alm_pre_alarma", alarma);
    wait_ticks(1);
    push(2); pop_chk("alm_match_min", minuto);
    push(1); pop_chk("alm_set", alarma);
    wait_ticks(59);
    push(1); pop_chk("alm_hold59", alarma);
    wait_ticks(1);
    push(0); pop_chk("alm_timeout_clr", alarma);

    // Manual entry of the match time must not trigger
    set_mode(2'b10);
    k = (62 - int'(minuto)) % 60;
    repeat (k) press_inc();
    push(2); pop_chk("man_min", minuto);
    push(0); pop_chk("man_alarma_m10", alarma);
    set_mode(2'b00);
    wait_ticks(1);
    push(0); pop_chk("man_alarma_run", alarma);

    // Repeat alarm, cancel with an inc press after 3 ticks
    set_mode(2'b10);
    k = (61 - int'(minuto)) % 60;
    repeat (k) press_inc();
    push(1); pop_chk("rep_setup_min", minuto);
    set_mode(2'b00);
    wait_ticks(60);
    push(1); pop_chk("rep_set", alarma);
    wait_ticks(3);
    btn_inc = 1'b1;
    cyc(2);
    push(1); pop_chk("rep_before_cancel", alarma);
    cyc(1);
    push(0); pop_chk("rep_cancel", alarma);
    push(2); pop_chk("rep_m00_min_kept", minuto);
    btn_inc = 1'b0;
    cyc(5);

    // Asynchronous reset in the middle of an adjust
    set_mode(2'b01);
    press_inc();
    btn_inc = 1'b1;
    cyc(1);
    #2 rst_n = 1'b0;
    #1;
    push(0); pop_chk("arst_hora", hora);
    push(0); pop_chk("arst_min", minuto);
    push(6); pop_chk("arst_alm_hora", alm_hora);
    push(0); pop_chk("arst_alm_min", alm_min);
    push(0); pop_chk("arst_alarma", alarma);
    btn_inc = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
